// File: rtl/cheat_loader.sv
// cheat_loader: producer side of the cheat-code load interface.
// Assembles 16-byte records from the HPS download byte stream into the
// 129-bit {strobe, flags, address, compare, replace} word for the matching
// engine, paces one clean strobe edge per record, and pulses codes_clear at
// the start of each download.
// Optional: `define CHEAT_LOADER_ZERO_SKIP_EN to drop all-zero (padding) records.
module cheat_loader #(
  parameter int MAX_CODES   = 32,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dl_active,
  input  logic                           dl_wr,
  input  logic [7:0]                     dl_data,
  output logic                           dl_ready,
  output logic                           codes_clear,
  output logic [128:0]                   code,
  output logic [$clog2(MAX_CODES+1)-1:0] code_count,
  output logic                           overflow,
  output logic                           partial
);

  localparam int CW = $clog2(MAX_CODES+1);
  localparam int HW = $clog2(HOLD_CYCLES+1);

  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, STROBE_HI, STROBE_LO} state_t;

  state_t        state, next_state;
  logic [127:0]  code_q;
  logic [3:0]    idx;
  logic [HW-1:0] hold_cnt;
  logic          act_q;
  logic          accept, last_byte, rec_keep, hold_done, room;
  logic [6:0]    pos;

  // Field f = idx>>2 sits at code[127-32f -: 32]; byte b = idx&3 fills bits [8b+7:8b]
  // of that field, so the little-endian file field lands as a numeric value.
  assign pos       = 7'd96 - {idx[3:2], 5'd0} + {2'd0, idx[1:0], 3'd0};
  assign accept    = (state == COLLECT) && dl_active && dl_wr;
  assign last_byte = accept && (idx == 4'd15);
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES-1));
  assign room      = (code_count < CW'(MAX_CODES));

`ifdef CHEAT_LOADER_ZERO_SKIP_EN
  logic nz_q, nz_next;
  assign nz_next  = ((idx == 4'd0) ? 1'b0 : nz_q) | (|dl_data);
  assign rec_keep = nz_next;

  // Running OR of the record's accepted bytes, restarted at byte 0.
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) nz_q <= 1'b0;
    else if (accept)             nz_q <= nz_next;
  end
`else
  assign rec_keep = 1'b1;
`endif

  assign dl_ready    = (state == COLLECT);
  assign codes_clear = (state == CLEAR);
  assign code        = {state == STROBE_HI, code_q};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (dl_active && !act_q) next_state = CLEAR;
      CLEAR:     next_state = COLLECT;
      COLLECT: begin
        if (!dl_active)                        next_state = IDLE;
        else if (last_byte && rec_keep && room) next_state = STROBE_HI;
      end
      STROBE_HI: if (hold_done) next_state = STROBE_LO;
      STROBE_LO: if (hold_done) next_state = dl_active ? COLLECT : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Record assembly, strobe pacing, counters and sticky status.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q     <= '0;
      idx        <= '0;
      hold_cnt   <= '0;
      act_q      <= 1'b0;
      code_count <= '0;
      overflow   <= 1'b0;
      partial    <= 1'b0;
    end else begin
      act_q <= dl_active;
      if ((state == STROBE_HI || state == STROBE_LO) && !hold_done) hold_cnt <= hold_cnt + 1'b1;
      else                                                         hold_cnt <= '0;
      case (state)
        CLEAR: begin
          code_q     <= '0;
          idx        <= '0;
          code_count <= '0;
          overflow   <= 1'b0;
          partial    <= 1'b0;
        end
        COLLECT: begin
          if (!dl_active) begin
            if (idx != 4'd0) partial <= 1'b1;
            idx <= '0;
          end else if (accept) begin
            code_q[pos +: 8] <= dl_data;
            idx              <= idx + 1'b1;  // wraps to 0 after byte 15
            if (last_byte && rec_keep && !room) overflow <= 1'b1;
          end
        end
        STROBE_LO: if (hold_done && room) code_count <= code_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cheat_loader.sv
// Directed, table-driven bench for cheat_loader (MAX_CODES=32, HOLD_CYCLES=2).
module tb_cheat_loader;

  logic         clk = 1'b0;
  logic         reset, dl_active, dl_wr;
  logic [7:0]   dl_data;
  logic         dl_ready, codes_clear, overflow, partial;
  logic [128:0] code;
  logic [5:0]   code_count;

  int n_cmp = 0;
  int n_err = 0;
  int rises = 0;
  logic prev_stb = 1'b0;

  cheat_loader #(.MAX_CODES(32), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_data(dl_data),
    .dl_ready(dl_ready), .codes_clear(codes_clear), .code(code),
    .code_count(code_count), .overflow(overflow), .partial(partial)
  );

  always #5 clk = ~clk;

  // Strobe rising-edge counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (code[128] && !prev_stb) rises++;
    prev_stb = code[128];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [0:15][7:0] stream;
    logic [127:0]     exp;
  } vec_t;

  vec_t vecs [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    dl_wr   = 1'b1;
    dl_data = b;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic send_rec(input logic [0:15][7:0] s);
    for (int i = 0; i < 16; i++) send_byte(s[i]);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!dl_ready && k < 50) begin
      tick();
      k++;
    end
    if (!dl_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: dl_ready stayed 0 expected 1");
    end
  endtask

  task automatic start_dl();
    dl_active = 1'b0;
    tick();
    tick();
    dl_active = 1'b1;
    tick();
    chk("clear_pulse", codes_clear, 1);
    tick();
    chk("clear_end", codes_clear, 0);
    chk("ready_after_clear", dl_ready, 1);
    chk("count_after_clear", code_count, 0);
    chk("overflow_after_clear", overflow, 0);
    chk("partial_after_clear", partial, 0);
  endtask

  // Checks the hi,hi,lo,lo strobe pattern starting in the cycle after byte 15.
  task automatic chk_strobe(input logic [127:0] exp);
    for (int c = 0; c < 4; c++) begin
      chk("strobe_bit", code[128], (c < 2) ? 1 : 0);
      chk("ready_during_strobe", dl_ready, 0);
      chk("data_during_strobe", code[127:0], exp);
      if (c < 3) tick();
    end
  endtask

  initial begin
    logic [0:15][7:0] s;
    int r0;

    vecs[0].stream = 128'h01000000341200_00AA000000BB000000;
    vecs[0].exp    = 128'h00000001_00001234_000000AA_000000BB;
    vecs[1].stream = 128'h78563412EFBEADDE00000080FFFFFFFF;
    vecs[1].exp    = 128'h12345678_DEADBEEF_80000000_FFFFFFFF;
    vecs[2].stream = 128'h0102030405060708090A0B0C0D0E0F10;
    vecs[2].exp    = 128'h04030201_08070605_0C0B0A09_100F0E0D;

    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'h00;
    repeat (3) tick();
    chk("rst_ready", dl_ready, 0);
    chk("rst_clear", codes_clear, 0);
    chk("rst_code", code, 0);
    chk("rst_count", code_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_partial", partial, 0);
    reset = 1'b0;
    tick();

    // Table-driven records; junk writes during the strobe must be ignored.
    start_dl();
    for (int v = 0; v < 3; v++) begin
      send_rec(vecs[v].stream);
      dl_wr = 1'b1; dl_data = 8'hEE;
      chk_strobe(vecs[v].exp);
      dl_wr = 1'b0;
      tick();
      chk("ready_after_strobe", dl_ready, 1);
      chk("count_after_strobe", code_count, 6'(v + 1));
    end

    // Reset mid-record: everything back to 0, no clear pulse.
    for (int i = 0; i < 5; i++) send_byte(8'h55);
    reset = 1'b1; dl_active = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_code", code, 0);
    chk("midrst_count", code_count, 0);
    chk("midrst_ready", dl_ready, 0);
    tick();
    chk("midrst_noclear", codes_clear, 0);

    // Partial record: 7 bytes then dl_active falls.
    start_dl();
    r0 = rises;
    for (int i = 0; i < 7; i++) send_byte(8'h11);
    dl_active = 1'b0;
    tick();
    chk("partial_set", partial, 1);
    chk("partial_ready", dl_ready, 0);
    chk("partial_nostrobe", code[128], 0);
    tick();
    chk("partial_rises", rises - r0, 0);
    start_dl();

    // dl_active drops the cycle after byte 15: strobe still completes, then IDLE.
    send_rec(vecs[0].stream);
    dl_active = 1'b0;
    chk_strobe(vecs[0].exp);
    tick();
    chk("drop_count", code_count, 1);
    chk("drop_ready", dl_ready, 0);
    tick(); tick();
    chk("drop_idle", dl_ready, 0);

    // All-zero record followed by a valid one.
    start_dl();
    r0 = rises;
    send_rec('0);
    wait_ready();
    send_rec(vecs[0].stream);
    wait_ready();
    tick();
`ifdef CHEAT_LOADER_ZERO_SKIP_EN
    chk("zero_count", code_count, 1);
    chk("zero_rises", rises - r0, 1);
`else
    chk("zero_count", code_count, 2);
    chk("zero_rises", rises - r0, 2);
`endif
    chk("zero_overflow", overflow, 0);

    // 33 records into a 32-entry table.
    start_dl();
    r0 = rises;
    for (int i = 0; i < 32; i++) begin
      s = '0;
      s[0] = 8'(i + 1);
      send_rec(s);
      wait_ready();
    end
    chk("ovf_count32", code_count, 32);
    chk("ovf_before", overflow, 0);
    s = '0;
    s[0] = 8'h77;
    send_rec(s);
    chk("ovf_set", overflow, 1);
    chk("ovf_ready", dl_ready, 1);
    chk("ovf_nostrobe", code[128], 0);
    repeat (6) tick();
    chk("ovf_rises", rises - r0, 32);
    chk("ovf_count_sat", code_count, 32);
    chk("ovf_sticky", overflow, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cheat_loader.md
Name: cheat_loader

Overview:
- Producer end of the cheat-code load interface.
- Takes the cheat file as a byte stream from the HPS download channel and assembles 16-byte records.
- Converts each little-endian 32-bit field into the big-endian 129-bit code word {strobe, flags, address, compare, replace} that the code-matching engine consumes.
- Paces the strobe bit so every record produces exactly one clean rising edge, and issues the engine's clear pulse when a new download starts.

Parameters:
- MAX_CODES, 32, maximum records strobed per download; later records are consumed and dropped.
- HOLD_CYCLES, 2, cycles the strobe is held high and then held low per record; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- dl_active  input  1  cheat download in progress; rising edge starts a new load.
- dl_wr  input  1  byte write strobe; accepted only when dl_wr && dl_ready.
- dl_data  input  8  download byte.
- dl_ready  output  1  loader can accept a byte this cycle.
- codes_clear  output  1  one-cycle pulse that clears the engine's code table.
- code  output  129  [128] strobe, [127:96] flags, [95:64] address, [63:32] compare, [31:0] replace.
- code_count  output  $clog2(MAX_CODES+1)  records strobed in the current download.
- overflow  output  1  a complete record arrived with code_count == MAX_CODES.
- partial  output  1  download ended with an incomplete record.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: every output is 0, FSM goes to IDLE, byte index = 0, stored dl_active = 0.
- States and transitions:
  - IDLE: dl_ready = 0. A rising edge of dl_active (registered compare) moves to CLEAR.
  - CLEAR: lasts 1 cycle. codes_clear = 1; code_count, overflow, partial, byte index and code[127:0] are cleared. Next state is COLLECT.
  - COLLECT: dl_ready = 1. Each accepted byte i (0..15) goes to field f = i>>2, byte b = i&3, written to code[127-32f-:32] bits [8b+7:8b] (the little-endian file field becomes a numeric value). Accepting byte 15 sets index to 0 and moves to STROBE_HI if code_count < MAX_CODES; otherwise it sets overflow and stays in COLLECT (record dropped, no strobe).
  - STROBE_HI: code[128] = 1 for HOLD_CYCLES cycles, dl_ready = 0. Next state is STROBE_LO.
  - STROBE_LO: code[128] = 0 for HOLD_CYCLES cycles, dl_ready = 0. code_count increments on the last cycle. Next state is COLLECT if dl_active = 1, otherwise IDLE.
- code[127:0] changes only in COLLECT and CLEAR, so it is stable throughout both strobe phases.
- First code[128] rise is 1 cycle after byte 15 is accepted.
- Minimum spacing between records: 2*HOLD_CYCLES cycles of backpressure after the last byte.
- dl_active falls in COLLECT with index != 0: set partial, discard the bytes, go to IDLE. With index == 0, go to IDLE silently.
- dl_active falls during STROBE_HI or STROBE_LO: the strobe completes (count increments), then go to IDLE.
- dl_wr while dl_ready = 0: byte is ignored, no state change.
- dl_active re-rises while not in IDLE: ignored. Only the IDLE-to-active edge restarts.
- reset mid-download: immediate return to IDLE with all outputs 0. No codes_clear pulse is generated; the engine has its own reset.
- code_count saturates at MAX_CODES. overflow and partial are sticky until the next CLEAR or reset.

Optional Feature:
- Macro: CHEAT_LOADER_ZERO_SKIP_EN.
- Defined: a completed record whose 16 bytes are all 0x00 (empty slot padding) produces no strobe and no count, and does not set overflow; FSM stays in COLLECT. Detection uses a running OR of accepted bytes, reset at index 0.
- Undefined: all-zero records are strobed and counted like any other record.

Test Plan:
- Reset, raise dl_active -> codes_clear high exactly 1 cycle, code_count = 0, dl_ready = 1 on the following cycle.
- Bytes 01 00 00 00 34 12 00 00 AA 00 00 00 BB 00 00 00 -> code[127:0] = 0x00000001_00001234_000000AA_000000BB; code[128] high 2 cycles then low 2 cycles; code_count = 1; dl_ready = 0 for 4 cycles.
- Send 33 valid records with MAX_CODES = 32 -> exactly 32 rising edges on code[128], code_count = 32, overflow = 1 after the 33rd record's byte 15.
- Send 7 bytes, then drop dl_active -> partial = 1, no strobe, FSM in IDLE, dl_ready = 0. Re-raise dl_active -> partial cleared by CLEAR.
- Drop dl_active on the cycle after byte 15 -> full strobe sequence still occurs, code_count = 1, then IDLE.
- All-zero record followed by a valid record -> with CHEAT_LOADER_ZERO_SKIP_EN: 1 strobe, code_count = 1. Without: 2 strobes, code_count = 2.
